// File: rtl/braille_round_sequencer.sv
// Multi-round Braille training sequencer: symbol request, timed answer capture, grader hand-off.
// Optional build macro BRAILLE_EARLY_ADVANCE_EN lets the skip strobe end a round like a timeout.
module braille_round_sequencer #(
    parameter int NUM_ROUNDS = 5,
    parameter int DATA_W     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode,
    input  logic                         update,
    input  logic                         timeout2sec,
    input  logic                         skip,
    input  logic [DATA_W-1:0]            rain,
    output logic                         reqlfsr,
    output logic                         req2sec,
    output logic                         segen,
    output logic                         allowgt,
    output logic [NUM_ROUNDS*DATA_W-1:0] raout,
    output logic [3:0]                   round_idx,
    output logic                         busy
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        REQ,
        LOAD,
        WAIT,
        STOP
    } state_e;

    state_e                       state_q;
    logic                         reqlfsr_q;
    logic                         req2sec_q;
    logic                         segen_q;
    logic                         allowgt_q;
    logic                         busy_q;
    logic [3:0]                   idx_q;
    logic [NUM_ROUNDS*DATA_W-1:0] raout_q;
    logic [NUM_ROUNDS*DATA_W-1:0] raout_d;
    logic                         round_done;

`ifdef BRAILLE_EARLY_ADVANCE_EN
    assign round_done = timeout2sec | skip;
`else
    logic unused_skip;
    assign unused_skip = skip;
    assign round_done  = timeout2sec;
`endif

    // Only the slot addressed by the current round follows the live input.
    always_comb begin
        raout_d = raout_q;
        for (int k = 0; k < NUM_ROUNDS; k++) begin
            if (idx_q == 4'(k)) begin
                raout_d[k*DATA_W +: DATA_W] = rain;
            end
        end
    end

    // A low mode aborts from any state; in IDLE it simply keeps the cleared outputs.
    always_ff @(posedge clk) begin
        if (!rst || !mode) begin
            state_q   <= IDLE;
            reqlfsr_q <= 1'b0;
            req2sec_q <= 1'b0;
            segen_q   <= 1'b0;
            allowgt_q <= 1'b0;
            busy_q    <= 1'b0;
            idx_q     <= '0;
            raout_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= START;
                end
                START: begin
                    if (update) begin
                        allowgt_q <= 1'b0;
                        raout_q   <= '0;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    reqlfsr_q <= 1'b1;
                    segen_q   <= 1'b1;
                    req2sec_q <= 1'b1;
                    state_q   <= LOAD;
                end
                LOAD: begin
                    reqlfsr_q <= 1'b0;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    raout_q <= raout_d;
                    if (round_done) begin
                        req2sec_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            busy_q  <= 1'b0;
                            state_q <= STOP;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            state_q <= REQ;
                        end
                    end
                end
                STOP: begin
                    allowgt_q <= 1'b1;
                    segen_q   <= 1'b0;
                    idx_q     <= '0;
                    state_q   <= START;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign reqlfsr   = reqlfsr_q;
    assign req2sec   = req2sec_q;
    assign segen     = segen_q;
    assign allowgt   = allowgt_q;
    assign raout     = raout_q;
    assign round_idx = idx_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_braille_round_sequencer.sv
// Randomised bench for braille_round_sequencer; expectations come from a per-round timeline model.
module tb_braille_round_sequencer;

    localparam int NR = 5;
    localparam int DW = 4;
`ifdef BRAILLE_EARLY_ADVANCE_EN
    localparam bit EA = 1'b1;
`else
    localparam bit EA = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              mode;
    logic              update;
    logic              timeout2sec;
    logic              skip;
    logic [DW-1:0]     rain;
    logic              reqlfsr;
    logic              req2sec;
    logic              segen;
    logic              allowgt;
    logic [NR*DW-1:0]  raout;
    logic [3:0]        round_idx;
    logic              busy;

    int n_chk  = 0;
    int n_fail = 0;
    int pulse_cnt = 0;
    logic [DW-1:0] slot_m [NR];

    braille_round_sequencer #(.NUM_ROUNDS(NR), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .update     (update),
        .timeout2sec(timeout2sec),
        .skip       (skip),
        .rain       (rain),
        .reqlfsr    (reqlfsr),
        .req2sec    (req2sec),
        .segen      (segen),
        .allowgt    (allowgt),
        .raout      (raout),
        .round_idx  (round_idx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NR*DW-1:0] pack_slots();
        logic [NR*DW-1:0] v = '0;
        for (int k = 0; k < NR; k++) v[k*DW +: DW] = slot_m[k];
        return v;
    endfunction

    task automatic clear_slots();
        for (int k = 0; k < NR; k++) slot_m[k] = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        pulse_cnt += int'(reqlfsr);
    endtask

    task automatic chk_outs(input string ph, input bit rq, input bit r2, input bit sg,
                            input bit al, input int idx, input bit bz);
        chk({ph, ".reqlfsr"},   reqlfsr,   rq);
        chk({ph, ".req2sec"},   req2sec,   r2);
        chk({ph, ".segen"},     segen,     sg);
        chk({ph, ".allowgt"},   allowgt,   al);
        chk({ph, ".round_idx"}, round_idx, idx);
        chk({ph, ".busy"},      busy,      bz);
        chk({ph, ".raout"},     raout,     pack_slots());
    endtask

    // kind 0: random, 1: rain k+3 with 4 extra WAIT cycles, 2: skip on first WAIT cycle.
    task automatic play_game(input int kind, input int abort_round, input bit abort_rst);
        int w [NR];
        int pick;
        bit aborted = 1'b0;
        logic [DW-1:0] r;
        logic [NR*DW-1:0] exp_dir = '0;
        for (int k = 0; k < NR; k++) begin
            case (kind)
                1:       w[k] = 4;
                2:       w[k] = EA ? 0 : 1;
                default: w[k] = $urandom_range(0, 3);
            endcase
            exp_dir[k*DW +: DW] = DW'(k + 3);
        end
        pulse_cnt   = 0;
        update      = 1'b1;
        timeout2sec = 1'($urandom_range(0, 1));
        skip        = 1'($urandom_range(0, 1));
        step();
        update = 1'b0;
        clear_slots();
        for (int k = 0; k < NR && !aborted; k++) begin
            chk_outs("req", 1'b0, 1'b0, k != 0, 1'b0, k, 1'b1);
            update      = 1'($urandom_range(0, 1));
            timeout2sec = 1'($urandom_range(0, 1));
            skip        = 1'($urandom_range(0, 1));
            step();
            chk_outs("load", 1'b1, 1'b1, 1'b1, 1'b0, k, 1'b1);
            timeout2sec = 1'($urandom_range(0, 1));
            skip        = 1'($urandom_range(0, 1));
            step();
            update = 1'b0;
            chk_outs("wait0", 1'b0, 1'b1, 1'b1, 1'b0, k, 1'b1);
            for (int j = 0; j <= w[k]; j++) begin
                if (kind == 1) r = (k == 0) ? ((j == w[k]) ? DW'(3) : DW'(j + 1)) : DW'(k + 3);
                else           r = DW'($urandom_range(0, (1 << DW) - 1));
                rain = r;
                if (k == abort_round && j == 0) begin
                    if (abort_rst) rst = 1'b0;
                    else           mode = 1'b0;
                    timeout2sec = 1'($urandom_range(0, 1));
                    skip        = 1'($urandom_range(0, 1));
                    update      = 1'($urandom_range(0, 1));
                    step();
                    rst = 1'b1; mode = 1'b1; update = 1'b0;
                    clear_slots();
                    chk_outs("abort", 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
                    step();
                    chk_outs("restart", 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
                    aborted = 1'b1;
                    break;
                end
                if (j < w[k]) begin
                    timeout2sec = 1'b0;
                    skip        = EA ? 1'b0 : 1'($urandom_range(0, 1));
                    if (kind == 2 && j == 0) skip = 1'b1;
                end else if (!EA) begin
                    timeout2sec = 1'b1;
                    skip        = 1'($urandom_range(0, 1));
                end else begin
                    pick = (kind == 2) ? 1 : $urandom_range(0, 2);
                    timeout2sec = (pick != 1);
                    skip        = (pick != 0);
                end
                step();
                slot_m[k] = r;
                if (j < w[k]) chk_outs("wait", 1'b0, 1'b1, 1'b1, 1'b0, k, 1'b1);
                timeout2sec = 1'b0;
                skip        = 1'b0;
            end
        end
        if (!aborted) begin
            chk_outs("stop", 1'b0, 1'b0, 1'b1, 1'b0, NR - 1, 1'b0);
            timeout2sec = 1'($urandom_range(0, 1));
            step();
            chk_outs("done", 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
            chk("reqlfsr_pulses", pulse_cnt, NR);
            if (kind == 1) chk("raout_directed", raout, exp_dir);
            repeat ($urandom_range(0, 2)) begin
                timeout2sec = 1'($urandom_range(0, 1));
                skip        = 1'($urandom_range(0, 1));
                step();
                chk_outs("hold", 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
            end
            timeout2sec = 1'b0;
            skip        = 1'b0;
        end
    endtask

    initial begin
        int ab;
        rst = 1'b0; mode = 1'b1; update = 1'b0; timeout2sec = 1'b0; skip = 1'b0; rain = '0;
        clear_slots();
        step();
        step();
        rst = 1'b1; mode = 1'b0;
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        update = 1'b1; timeout2sec = 1'b1;
        step();
        chk_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        update = 1'b0; timeout2sec = 1'b0; mode = 1'b1;
        step();
        chk_outs("start", 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        play_game(1, -1, 1'b0);
        play_game(1, -1, 1'b0);
        play_game(2, -1, 1'b0);
        play_game(0, 2, 1'b0);
        play_game(0, 1, 1'b1);
        for (int g = 0; g < 24; g++) begin
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NR - 1)) : -1;
            play_game(0, ab, 1'($urandom_range(0, 1)));
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
